// File: rtl/btn_debounce_filter_if.sv
// Button pins and debounced outputs/strobes between the panel-side source and the debouncer.
interface btn_debounce_filter_if #(
    parameter int unsigned N_BTN = 2
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_out;
    logic [N_BTN-1:0] press_pulse;
    logic [N_BTN-1:0] release_pulse;
    logic [N_BTN-1:0] long_pulse;
    logic [N_BTN-1:0] long_held;

    modport master (
        output btn_raw,
        input  btn_out,
        input  press_pulse,
        input  release_pulse,
        input  long_pulse,
        input  long_held
    );

    modport slave (
        input  btn_raw,
        output btn_out,
        output press_pulse,
        output release_pulse,
        output long_pulse,
        output long_held
    );
endinterface

// File: rtl/btn_debounce_filter.sv
// Per-channel push-button debouncer: 2-flop synchroniser, stable-level filter,
// press/release strobes and optional long-press detection.
module btn_debounce_filter #(
    parameter int unsigned N_BTN           = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned LONG_CYCLES     = 0,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    btn_debounce_filter_if.slave  bus
);
    localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned LONG_W = (LONG_CYCLES > 0) ? $clog2(LONG_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'((LONG_CYCLES > 0) ? LONG_CYCLES - 1 : 0);
    localparam logic [LONG_W-1:0] LONG_SAT  = LONG_W'(LONG_CYCLES);
    localparam logic IDLE_LVL  = ACTIVE_LOW;
    localparam logic PRESS_LVL = ~ACTIVE_LOW;

    typedef enum logic [1:0] {
        S_RELEASED,
        S_PRESS_WAIT,
        S_PRESSED,
        S_RELEASE_WAIT
    } state_t;

    logic [N_BTN-1:0] r_sync1;
    logic [N_BTN-1:0] r_sync2;
    logic [N_BTN-1:0] w_btn_out;
    logic [N_BTN-1:0] w_press;
    logic [N_BTN-1:0] w_release;
    logic [N_BTN-1:0] w_long;
    logic [N_BTN-1:0] w_held;

    // Two-flop synchroniser; reset forces the idle level so a held pin reads as a new press.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= {N_BTN{IDLE_LVL}};
            r_sync2 <= {N_BTN{IDLE_LVL}};
        end else begin
            r_sync1 <= bus.btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        state_t            r_state,    w_state_nx;
        logic [CNT_W-1:0]  r_cnt,      w_cnt_nx;
        logic [LONG_W-1:0] r_long_cnt, w_long_cnt_nx;
        logic              r_out,      w_out_nx;
        logic              r_press,    w_press_nx;
        logic              r_rel,      w_rel_nx;
        logic              r_long,     w_long_nx;
        logic              r_held,     w_held_nx;
        logic              w_pressed;

        assign w_pressed = (r_sync2[g] == PRESS_LVL);

        always_ff @(posedge clk) begin
            if (reset) begin
                r_state    <= S_RELEASED;
                r_cnt      <= '0;
                r_long_cnt <= '0;
                r_out      <= IDLE_LVL;
                r_press    <= 1'b0;
                r_rel      <= 1'b0;
                r_long     <= 1'b0;
                r_held     <= 1'b0;
            end else begin
                r_state    <= w_state_nx;
                r_cnt      <= w_cnt_nx;
                r_long_cnt <= w_long_cnt_nx;
                r_out      <= w_out_nx;
                r_press    <= w_press_nx;
                r_rel      <= w_rel_nx;
                r_long     <= w_long_nx;
                r_held     <= w_held_nx;
            end
        end

        always_comb begin
            w_state_nx    = r_state;
            w_cnt_nx      = r_cnt;
            w_long_cnt_nx = r_long_cnt;
            w_out_nx      = r_out;
            w_press_nx    = 1'b0;
            w_rel_nx      = 1'b0;
            w_long_nx     = 1'b0;
            w_held_nx     = r_held;

            unique case (r_state)
                S_RELEASED: begin
                    w_long_cnt_nx = '0;
                    if (w_pressed) begin
                        w_state_nx = S_PRESS_WAIT;
                        w_cnt_nx   = CNT_W'(1);
                    end
                end
                S_PRESS_WAIT: begin
                    if (!w_pressed) begin
                        w_state_nx = S_RELEASED;
                        w_cnt_nx   = '0;
                    end else if (r_cnt == CNT_LAST) begin
                        w_state_nx = S_PRESSED;
                        w_cnt_nx   = '0;
                        w_out_nx   = PRESS_LVL;
                        w_press_nx = 1'b1;
                    end else begin
                        w_cnt_nx = r_cnt + CNT_W'(1);
                    end
                end
                S_PRESSED: begin
                    if (!w_pressed) begin
                        w_state_nx = S_RELEASE_WAIT;
                        w_cnt_nx   = CNT_W'(1);
                    end
                end
                S_RELEASE_WAIT: begin
                    if (w_pressed) begin
                        w_state_nx = S_PRESSED;
                        w_cnt_nx   = '0;
                    end else if (r_cnt == CNT_LAST) begin
                        w_state_nx    = S_RELEASED;
                        w_cnt_nx      = '0;
                        w_out_nx      = IDLE_LVL;
                        w_rel_nx      = 1'b1;
                        w_held_nx     = 1'b0;
                        w_long_cnt_nx = '0;
                    end else begin
                        w_cnt_nx = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nx = S_RELEASED;
                    w_cnt_nx   = '0;
                end
            endcase

            // Long-press timer spans release bounce; an accepted release on the same edge wins.
            if ((LONG_CYCLES > 0) && !w_rel_nx &&
                (r_state == S_PRESSED || r_state == S_RELEASE_WAIT)) begin
                if (r_long_cnt == LONG_LAST) begin
                    w_long_nx = 1'b1;
                    w_held_nx = 1'b1;
                end
                if (r_long_cnt != LONG_SAT) begin
                    w_long_cnt_nx = r_long_cnt + LONG_W'(1);
                end
            end
        end

        assign w_btn_out[g] = r_out;
        assign w_press[g]   = r_press;
        assign w_release[g] = r_rel;
        assign w_long[g]    = r_long;
        assign w_held[g]    = r_held;
    end

    assign bus.btn_out       = w_btn_out;
    assign bus.press_pulse   = w_press;
    assign bus.release_pulse = w_release;
    assign bus.long_pulse    = w_long;
    assign bus.long_held     = w_held;
endmodule

// File: tb/tb_btn_debounce_filter.sv
// Directed bench for btn_debounce_filter: N_BTN=2, DEBOUNCE_CYCLES=4, LONG_CYCLES=10, active-low pins.
module tb_btn_debounce_filter;
    localparam int unsigned N_BTN = 2;
    localparam int unsigned DEB   = 4;
    localparam int unsigned LONG  = 10;

    logic clk = 1'b0;
    logic reset;
    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    always #5 clk = ~clk;

    btn_debounce_filter_if #(.N_BTN(N_BTN)) bus ();

    btn_debounce_filter #(
        .N_BTN(N_BTN),
        .DEBOUNCE_CYCLES(DEB),
        .LONG_CYCLES(LONG),
        .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [1:0] out, input logic [1:0] press,
                             input logic [1:0] rel, input logic [1:0] lp, input logic [1:0] lh);
        check({tag, ".out"},   32'(bus.btn_out),       32'(out));
        check({tag, ".press"}, 32'(bus.press_pulse),   32'(press));
        check({tag, ".rel"},   32'(bus.release_pulse), 32'(rel));
        check({tag, ".long"},  32'(bus.long_pulse),    32'(lp));
        check({tag, ".held"},  32'(bus.long_held),     32'(lh));
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset       = 1'b1;
        bus.btn_raw = 2'b11;
        step(3);
        check_all("t1.reset", 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);

        // basic press on channel 0, accepted on edge 6
        reset       = 1'b0;
        bus.btn_raw = 2'b10;
        step(5);
        check_all("t1.e5", 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
        step(1);
        check_all("t1.e6", 2'b10, 2'b01, 2'b00, 2'b00, 2'b00);
        step(1);
        check_all("t1.e7", 2'b10, 2'b00, 2'b00, 2'b00, 2'b00);
        bus.btn_raw = 2'b11;
        step(5);
        check_all("t1.rel5", 2'b10, 2'b00, 2'b00, 2'b00, 2'b00);
        step(1);
        check_all("t1.rel6", 2'b11, 2'b00, 2'b01, 2'b00, 2'b00);
        step(3);

        // bounce: low 3, high 1, then low held
        bus.btn_raw = 2'b10;
        for (int i = 0; i < 3; i++) begin
            step(1);
            check_all("t2.low", 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
        end
        bus.btn_raw = 2'b11;
        step(1);
        check_all("t2.high", 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
        bus.btn_raw = 2'b10;
        step(5);
        check_all("t2.e5", 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
        step(1);
        check_all("t2.e6", 2'b10, 2'b01, 2'b00, 2'b00, 2'b00);
        bus.btn_raw = 2'b11;
        step(5);
        check_all("t2.rel5", 2'b10, 2'b00, 2'b00, 2'b00, 2'b00);
        step(1);
        check_all("t2.rel6", 2'b11, 2'b00, 2'b01, 2'b00, 2'b00);
        step(2);

        // long press on channel 1
        bus.btn_raw = 2'b01;
        step(5);
        check_all("t3.e5", 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
        step(1);
        check_all("t3.e6", 2'b01, 2'b10, 2'b00, 2'b00, 2'b00);
        step(9);
        check_all("t3.e15", 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
        step(1);
        check_all("t3.e16", 2'b01, 2'b00, 2'b00, 2'b10, 2'b10);
        step(1);
        check_all("t3.e17", 2'b01, 2'b00, 2'b00, 2'b00, 2'b10);
        bus.btn_raw = 2'b11;
        step(5);
        check_all("t3.rel5", 2'b01, 2'b00, 2'b00, 2'b00, 2'b10);
        step(1);
        check_all("t3.rel6", 2'b11, 2'b00, 2'b10, 2'b00, 2'b00);
        step(2);

        // short press: release acceptance coincides with long threshold, release wins
        bus.btn_raw = 2'b10;
        step(6);
        check_all("t4a.e6", 2'b10, 2'b01, 2'b00, 2'b00, 2'b00);
        step(4);
        bus.btn_raw = 2'b11;
        step(5);
        check_all("t4a.e15", 2'b10, 2'b00, 2'b00, 2'b00, 2'b00);
        step(1);
        check_all("t4a.e16", 2'b11, 2'b00, 2'b01, 2'b00, 2'b00);
        step(1);
        check_all("t4a.e17", 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
        step(2);

        // release bounce keeps the long timer running: long at e16, release at e18
        bus.btn_raw = 2'b10;
        step(6);
        check_all("t4b.e6", 2'b10, 2'b01, 2'b00, 2'b00, 2'b00);
        step(4);
        bus.btn_raw = 2'b11;
        step(1);
        bus.btn_raw = 2'b10;
        step(1);
        bus.btn_raw = 2'b11;
        step(3);
        check_all("t4b.e15", 2'b10, 2'b00, 2'b00, 2'b00, 2'b00);
        step(1);
        check_all("t4b.e16", 2'b10, 2'b00, 2'b00, 2'b01, 2'b01);
        step(1);
        check_all("t4b.e17", 2'b10, 2'b00, 2'b00, 2'b00, 2'b01);
        step(1);
        check_all("t4b.e18", 2'b11, 2'b00, 2'b01, 2'b00, 2'b00);
        step(2);

        // short press with release bounce: acceptance delayed to e14, no long
        bus.btn_raw = 2'b10;
        step(6);
        check_all("t4c.e6", 2'b10, 2'b01, 2'b00, 2'b00, 2'b00);
        bus.btn_raw = 2'b11;
        step(1);
        bus.btn_raw = 2'b10;
        step(1);
        bus.btn_raw = 2'b11;
        step(4);
        check_all("t4c.e12", 2'b10, 2'b00, 2'b00, 2'b00, 2'b00);
        step(1);
        check_all("t4c.e13", 2'b10, 2'b00, 2'b00, 2'b00, 2'b00);
        step(1);
        check_all("t4c.e14", 2'b11, 2'b00, 2'b01, 2'b00, 2'b00);
        step(2);

        // both channels together, staggered releases
        bus.btn_raw = 2'b00;
        step(5);
        check_all("t5.e5", 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
        step(1);
        check_all("t5.e6", 2'b00, 2'b11, 2'b00, 2'b00, 2'b00);
        step(1);
        bus.btn_raw = 2'b01;
        step(2);
        bus.btn_raw = 2'b11;
        step(3);
        check_all("t5.e12", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        step(1);
        check_all("t5.e13", 2'b01, 2'b00, 2'b01, 2'b00, 2'b00);
        step(1);
        check_all("t5.e14", 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
        step(1);
        check_all("t5.e15", 2'b11, 2'b00, 2'b10, 2'b00, 2'b00);
        step(2);

        // reset with ch1 long-held and ch0 mid-wait, pins held low through reset
        bus.btn_raw = 2'b01;
        step(13);
        bus.btn_raw = 2'b00;
        step(3);
        check_all("t6.pre", 2'b01, 2'b00, 2'b00, 2'b10, 2'b10);
        reset = 1'b1;
        step(1);
        check_all("t6.rst", 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
        reset = 1'b0;
        step(5);
        check_all("t6.e5", 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
        step(1);
        check_all("t6.e6", 2'b00, 2'b11, 2'b00, 2'b00, 2'b00);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
